ntt_stage_ctrl: RTL and testbench
=================================

Name: ntt_stage_ctrl

Overview:
- Sequencer that drives the NTT butterfly over a full N-point forward transform, in place in a dual-port coefficient RAM.
- Cooley-Tukey ordering: len = N/2 down to 1.
- Each cycle it issues one coefficient pair and one twiddle index.
- It aligns the read data with the butterfly inputs and writes the butterfly outputs back to the same addresses.
- Sits between the top-level start/done control and the butterfly plus coefficient/twiddle memories.

Parameters:
- N, 256, transform length (power of two).
- LOGN, 8, log2(N); equals the stage count.
- W, 13, coefficient and twiddle width.
- RAM_LAT, 1, read latency of the coefficient RAM and the twiddle ROM (they are identical).
- BF_LAT, 3, butterfly latency from in0/in1/phi to out0/out1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin transform; sampled in IDLE only.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at completion.
- rd_addr0  out  LOGN  RAM port A read address (index j).
- rd_addr1  out  LOGN  RAM port B read address (index j+len).
- rd_en  out  1  read strobe for both ports.
- rd_data0  in  W  port A read data, valid RAM_LAT cycles after rd_en.
- rd_data1  in  W  port B read data.
- tw_addr  out  LOGN  twiddle ROM index k.
- tw_data  in  W  twiddle, valid RAM_LAT cycles after rd_en.
- bf_in0  out  W  butterfly in0 (= rd_data0).
- bf_in1  out  W  butterfly in1 (= rd_data1).
- bf_phi  out  W  butterfly phi (= tw_data).
- bf_out0  in  W  butterfly out0.
- bf_out1  in  W  butterfly out1.
- wr_en  out  1  write strobe for both ports.
- wr_addr0  out  LOGN  write address for bf_out0.
- wr_addr1  out  LOGN  write address for bf_out1.
- wr_data0  out  W  equals bf_out0.
- wr_data1  out  W  equals bf_out1.

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, wr_en=0; all addresses 0; state IDLE; pipeline valid bits cleared.
- States:
  - IDLE: start=1 goes to RUN with len=N/2, k=1, group start=0, j=0, stage=0.
  - RUN: each cycle rd_en=1 with rd_addr0=j, rd_addr1=j+len, tw_addr=k.
    - j increments. When j reaches start+len-1, start becomes start+2*len, j becomes that new start, and k increments.
    - After N/2 issues the stage ends and the state goes to DRAIN.
  - DRAIN: exactly D=RAM_LAT+BF_LAT cycles with rd_en=0 (read-after-write hazard guard between stages). Then:
    - if stage<LOGN-1: stage+1, len>>=1, start=j=0, back to RUN; k continues without reset;
    - otherwise go to DONE.
  - DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Latency and write-back:
  - Read issued in cycle t; data on bf_in* in cycle t+RAM_LAT.
  - wr_en=1 with wr_addr0/1 equal to the issued addresses in cycle t+RAM_LAT+BF_LAT, via a D-deep address/valid shift register.
  - bf_in*/bf_phi/wr_data* are combinational pass-throughs.
- Total cycles from the start-sampling edge to the done pulse: LOGN*(N/2+D) (1056 at defaults).
- start while busy is ignored; start held high in DONE is not re-accepted until IDLE.
- reset mid-transform: next cycle is IDLE, wr_en=0, all in-flight valid bits dropped. The RAM is left partially transformed.
- Twiddle index k runs 1..N-1; tw_addr never takes the value 0.

Optional Feature:
- Macro: NTT_STAGE_CTRL_CYCCNT_EN.
- Enabled: adds output cycle_count [15:0].
  - Cleared on reset and on start acceptance.
  - Increments every busy cycle; holds its value after done (1056 at defaults).
- Disabled: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ntt_pkg:
  - N, LOGN, W, modulus Q=7681;
  - state enum type (IDLE, RUN, DRAIN, DONE);
  - derived D = RAM_LAT+BF_LAT.
- One natural sub-module: ntt_addr_gen. It holds the len/start/j/k/stage counters, exposes issue/stage_end/last_stage, and is unit-testable alone.
- The write-back delay line stays in the top module.

Test Plan:
- Reset then start=1 for 1 cycle:
  - first issue: rd_addr0=0, rd_addr1=128, tw_addr=1;
  - next cycle: 1/129/1;
  - 128th issue: 127/255/1.
- Stage 1 (len=64):
  - first issue 0/64 with tw_addr=2;
  - 65th issue 128/192 with tw_addr=3.
- Last stage (len=1): issues 0/1 tw 128, then 2/3 tw 129, ..., 254/255 tw 255. done pulses 1056 cycles after start; cycle_count=1056 when the feature is enabled.
- Write-back alignment: wr_en first rises 4 cycles after the first rd_en with wr_addr0=0, wr_addr1=128. No rd_en occurs during the 4 DRAIN cycles.
- Full transform with a bench RAM, twiddle ROM and a behavioural mod-7681 butterfly: input a[0]=1, rest 0 gives all 256 outputs = 1. Random vectors must match a software NTT.
- Assert reset during stage 3 (cycle 400): wr_en=0 and busy=0 the next cycle. start is ignored while busy, and a new start after reset gives a fresh 1056-cycle run.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and FSM state type for the NTT stage sequencer.
// Default sizing: 256-point transform, 13-bit coefficients modulo 7681.
package ntt_pkg;

    localparam int N       = 256;
    localparam int LOGN    = 8;
    localparam int W       = 13;
    localparam int Q       = 7681;
    localparam int RAM_LAT = 1;
    localparam int BF_LAT  = 3;
    // Read-to-write-back distance, also the number of idle cycles between stages
    localparam int D       = RAM_LAT + BF_LAT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ntt_addr_gen.sv
// Cooley-Tukey index generator: walks len = N/2 .. 1, emitting j, j+len and
// twiddle index k for one butterfly per issue cycle.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            init_i,
    input  logic            issue_i,
    input  logic            next_stage_i,
    output logic [LOGN-1:0] addr0_o,
    output logic [LOGN-1:0] addr1_o,
    output logic [LOGN-1:0] k_o,
    output logic            stage_end_o,
    output logic            last_stage_o
);

    localparam logic [LOGN-1:0] HALF = LOGN'(N / 2);

    logic [LOGN-1:0] len_q, len_d;
    logic [LOGN-1:0] grp_q, grp_d;
    logic [LOGN-1:0] j_q, j_d;
    logic [LOGN-1:0] k_q, k_d;
    logic [LOGN-1:0] stage_q, stage_d;
    logic [LOGN-2:0] cnt_q, cnt_d;
    logic            grp_end;

    assign grp_end      = (j_q == grp_q + len_q - 1'b1);
    assign stage_end_o  = (cnt_q == '1);
    assign last_stage_o = (stage_q == LOGN'(LOGN - 1));
    assign addr0_o      = j_q;
    assign addr1_o      = j_q + len_q;
    assign k_o          = k_q;

    always_comb begin
        len_d   = len_q;
        grp_d   = grp_q;
        j_d     = j_q;
        k_d     = k_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (init_i) begin
            len_d   = HALF;
            grp_d   = '0;
            j_d     = '0;
            k_d     = LOGN'(1);
            stage_d = '0;
            cnt_d   = '0;
        end else if (next_stage_i) begin
            stage_d = stage_q + 1'b1;
            len_d   = len_q >> 1;
            grp_d   = '0;
            j_d     = '0;
            cnt_d   = '0;
        end else if (issue_i) begin
            cnt_d = cnt_q + 1'b1;
            if (grp_end) begin
                grp_d = grp_q + (len_q << 1);
                j_d   = grp_q + (len_q << 1);
                // k stops at N-1 after the final group instead of wrapping to 0
                if (!(stage_end_o && last_stage_o)) begin
                    k_d = k_q + 1'b1;
                end
            end else begin
                j_d = j_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q   <= '0;
            grp_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            len_q   <= len_d;
            grp_q   <= grp_d;
            j_q     <= j_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/ntt_stage_ctrl.sv
// In-place forward NTT sequencer: issues reads, aligns write-back D cycles later.
// Optional NTT_STAGE_CTRL_CYCCNT_EN adds a 16-bit busy-cycle counter output.
module ntt_stage_ctrl
    import ntt_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] rd_addr0,
    output logic [LOGN-1:0] rd_addr1,
    output logic            rd_en,
    input  logic [W-1:0]    rd_data0,
    input  logic [W-1:0]    rd_data1,
    output logic [LOGN-1:0] tw_addr,
    input  logic [W-1:0]    tw_data,
    output logic [W-1:0]    bf_in0,
    output logic [W-1:0]    bf_in1,
    output logic [W-1:0]    bf_phi,
    input  logic [W-1:0]    bf_out0,
    input  logic [W-1:0]    bf_out1,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr0,
    output logic [LOGN-1:0] wr_addr1,
    output logic [W-1:0]    wr_data0,
    output logic [W-1:0]    wr_data1
`ifdef NTT_STAGE_CTRL_CYCCNT_EN
    ,
    output logic [15:0]     cycle_count
`endif
);

    localparam int DW = $clog2(D);

    state_e          state_q;
    logic            busy_q;
    logic            done_q;
    logic            rd_en_q;
    logic [DW-1:0]   drain_q;
    logic            accept;
    logic            issue;
    logic            drain_last;
    logic            next_stage;
    logic            stage_end;
    logic            last_stage;

    logic [D-1:0]    wv_q;
    logic [LOGN-1:0] wa0_q [D];
    logic [LOGN-1:0] wa1_q [D];

    assign accept     = (state_q == IDLE) && start;
    assign issue      = (state_q == RUN);
    assign drain_last = (drain_q == DW'(D - 1));
    assign next_stage = (state_q == DRAIN) && drain_last && !last_stage;

    ntt_addr_gen u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .init_i       (accept),
        .issue_i      (issue),
        .next_stage_i (next_stage),
        .addr0_o      (rd_addr0),
        .addr1_o      (rd_addr1),
        .k_o          (tw_addr),
        .stage_end_o  (stage_end),
        .last_stage_o (last_stage)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            drain_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (stage_end) begin
                        state_q <= DRAIN;
                        rd_en_q <= 1'b0;
                        drain_q <= '0;
                    end
                end
                DRAIN: begin
                    drain_q <= drain_q + 1'b1;
                    if (drain_last) begin
                        if (last_stage) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Issued addresses ride along with the data through RAM and butterfly
    always_ff @(posedge clk) begin
        if (reset) begin
            wv_q <= '0;
            for (int i = 0; i < D; i++) begin
                wa0_q[i] <= '0;
                wa1_q[i] <= '0;
            end
        end else begin
            wv_q     <= {wv_q[D-2:0], rd_en_q};
            wa0_q[0] <= rd_addr0;
            wa1_q[0] <= rd_addr1;
            for (int i = 1; i < D; i++) begin
                wa0_q[i] <= wa0_q[i-1];
                wa1_q[i] <= wa1_q[i-1];
            end
        end
    end

`ifdef NTT_STAGE_CTRL_CYCCNT_EN
    logic [15:0] cyc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else if (accept) begin
            cyc_q <= '0;
        end else if (busy_q) begin
            cyc_q <= cyc_q + 16'd1;
        end
    end

    assign cycle_count = cyc_q;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_en    = rd_en_q;
    assign bf_in0   = rd_data0;
    assign bf_in1   = rd_data1;
    assign bf_phi   = tw_data;
    assign wr_en    = wv_q[D-1];
    assign wr_addr0 = wa0_q[D-1];
    assign wr_addr1 = wa1_q[D-1];
    assign wr_data0 = bf_out0;
    assign wr_data1 = bf_out1;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Bench for ntt_stage_ctrl: coefficient RAM, twiddle ROM and mod-7681 butterfly
// models around the sequencer, table-checked address trace plus full transforms.
`timescale 1ns/1ps
module tb_ntt_stage_ctrl;
    import ntt_pkg::*;

    localparam int LOG_LEN = 1060;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            busy, done, rd_en, wr_en;
    logic [LOGN-1:0] rd_addr0, rd_addr1, tw_addr, wr_addr0, wr_addr1;
    logic [W-1:0]    rd_data0, rd_data1, tw_data;
    logic [W-1:0]    bf_in0, bf_in1, bf_phi, bf_out0, bf_out1;
    logic [W-1:0]    wr_data0, wr_data1;
`ifdef NTT_STAGE_CTRL_CYCCNT_EN
    logic [15:0]     cycle_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ntt_stage_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .rd_en    (rd_en),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .tw_addr  (tw_addr),
        .tw_data  (tw_data),
        .bf_in0   (bf_in0),
        .bf_in1   (bf_in1),
        .bf_phi   (bf_phi),
        .bf_out0  (bf_out0),
        .bf_out1  (bf_out1),
        .wr_en    (wr_en),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1)
`ifdef NTT_STAGE_CTRL_CYCCNT_EN
        , .cycle_count (cycle_count)
`endif
    );

    // ---------------- memory and butterfly models ----------------
    logic [W-1:0] mem [N];
    logic [W-1:0] rom [N];
    logic [W-1:0] rd0_q = '0, rd1_q = '0, tw_q = '0;
    logic [W-1:0] p0 [BF_LAT];
    logic [W-1:0] p1 [BF_LAT];

    assign rd_data0 = rd0_q;
    assign rd_data1 = rd1_q;
    assign tw_data  = tw_q;
    assign bf_out0  = p0[BF_LAT-1];
    assign bf_out1  = p1[BF_LAT-1];

    function automatic logic [W-1:0] bf_sum(input logic [W-1:0] a, b, phi);
        int unsigned t;
        t = (32'(phi) * 32'(b)) % Q;
        return W'((32'(a) + t) % Q);
    endfunction

    function automatic logic [W-1:0] bf_dif(input logic [W-1:0] a, b, phi);
        int unsigned t;
        t = (32'(phi) * 32'(b)) % Q;
        return W'((32'(a) + Q - t) % Q);
    endfunction

    always @(posedge clk) begin
        if (rd_en) begin
            rd0_q <= mem[rd_addr0];
            rd1_q <= mem[rd_addr1];
            tw_q  <= rom[tw_addr];
        end
        if (wr_en) begin
            mem[wr_addr0] <= wr_data0;
            mem[wr_addr1] <= wr_data1;
        end
    end

    always @(posedge clk) begin
        p0[0] <= bf_sum(bf_in0, bf_in1, bf_phi);
        p1[0] <= bf_dif(bf_in0, bf_in1, bf_phi);
        for (int i = 1; i < BF_LAT; i++) begin
            p0[i] <= p0[i-1];
            p1[i] <= p1[i-1];
        end
    end

    // ---------------- scoreboard helpers ----------------
    int unsigned ref_a [N];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sw_ntt();
        int k;
        int len;
        int st;
        int unsigned t;
        k = 1;
        for (len = N / 2; len >= 1; len = len / 2) begin
            for (st = 0; st < N; st = st + 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    t = (32'(rom[k]) * ref_a[j+len]) % Q;
                    ref_a[j+len] = (ref_a[j] + Q - t) % Q;
                    ref_a[j]     = (ref_a[j] + t) % Q;
                end
                k++;
            end
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < N; i++) begin
            mem[i]   = W'($urandom_range(0, Q - 1));
            ref_a[i] = 32'(mem[i]);
        end
        sw_ntt();
    endtask

    task automatic compare_mem(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s coef[%0d]", tag, i), mem[i], ref_a[i]);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles from the start-sampling edge to the done pulse, bounded
    task automatic run_full(input string tag);
        int c;
        bit seen;
        pulse_start();
        c = 0;
        seen = 1'b0;
        while (!seen && c < 1200) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else c++;
        end
        check({tag, " done_latency"}, c, 1056);
`ifdef NTT_STAGE_CTRL_CYCCNT_EN
        check({tag, " cycle_count"}, cycle_count, 1056);
`endif
        @(negedge clk);
        check({tag, " busy_after_done"}, busy, 0);
        compare_mem(tag);
    endtask

    // ---------------- address-trace table ----------------
    typedef struct {
        int              cyc;
        logic            rd_en;
        logic [LOGN-1:0] a0;
        logic [LOGN-1:0] a1;
        logic [LOGN-1:0] tw;
        logic            wr_en;
        logic [LOGN-1:0] w0;
        logic [LOGN-1:0] w1;
        logic            done;
    } vec_t;

    vec_t vq[$];

    logic            l_rd_en [LOG_LEN];
    logic            l_wr_en [LOG_LEN];
    logic            l_done  [LOG_LEN];
    logic            l_busy  [LOG_LEN];
    logic [LOGN-1:0] l_a0 [LOG_LEN];
    logic [LOGN-1:0] l_a1 [LOG_LEN];
    logic [LOGN-1:0] l_tw [LOG_LEN];
    logic [LOGN-1:0] l_w0 [LOG_LEN];
    logic [LOGN-1:0] l_w1 [LOG_LEN];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rd;
        int n_wr;
        int n_tw0;
        int n_drain_rd;

        // cycle, rd_en, rd_addr0, rd_addr1, tw_addr, wr_en, wr_addr0, wr_addr1, done
        vq.push_back('{0,    1'b1, 8'd0,   8'd128, 8'd1,   1'b0, 8'd0,   8'd0,   1'b0});
        vq.push_back('{1,    1'b1, 8'd1,   8'd129, 8'd1,   1'b0, 8'd0,   8'd0,   1'b0});
        vq.push_back('{3,    1'b1, 8'd3,   8'd131, 8'd1,   1'b0, 8'd0,   8'd0,   1'b0});
        vq.push_back('{4,    1'b1, 8'd4,   8'd132, 8'd1,   1'b1, 8'd0,   8'd128, 1'b0});
        vq.push_back('{5,    1'b1, 8'd5,   8'd133, 8'd1,   1'b1, 8'd1,   8'd129, 1'b0});
        vq.push_back('{11,   1'b1, 8'd11,  8'd139, 8'd1,   1'b1, 8'd7,   8'd135, 1'b0});
        vq.push_back('{127,  1'b1, 8'd127, 8'd255, 8'd1,   1'b1, 8'd123, 8'd251, 1'b0});
        vq.push_back('{128,  1'b0, 8'd0,   8'd0,   8'd0,   1'b1, 8'd124, 8'd252, 1'b0});
        vq.push_back('{131,  1'b0, 8'd0,   8'd0,   8'd0,   1'b1, 8'd127, 8'd255, 1'b0});
        vq.push_back('{132,  1'b1, 8'd0,   8'd64,  8'd2,   1'b0, 8'd0,   8'd0,   1'b0});
        vq.push_back('{133,  1'b1, 8'd1,   8'd65,  8'd2,   1'b0, 8'd0,   8'd0,   1'b0});
        vq.push_back('{136,  1'b1, 8'd4,   8'd68,  8'd2,   1'b1, 8'd0,   8'd64,  1'b0});
        vq.push_back('{195,  1'b1, 8'd63,  8'd127, 8'd2,   1'b1, 8'd59,  8'd123, 1'b0});
        vq.push_back('{196,  1'b1, 8'd128, 8'd192, 8'd3,   1'b1, 8'd60,  8'd124, 1'b0});
        vq.push_back('{264,  1'b1, 8'd0,   8'd32,  8'd4,   1'b0, 8'd0,   8'd0,   1'b0});
        vq.push_back('{296,  1'b1, 8'd64,  8'd96,  8'd5,   1'b1, 8'd28,  8'd60,  1'b0});
        vq.push_back('{924,  1'b1, 8'd0,   8'd1,   8'd128, 1'b0, 8'd0,   8'd0,   1'b0});
        vq.push_back('{925,  1'b1, 8'd2,   8'd3,   8'd129, 1'b0, 8'd0,   8'd0,   1'b0});
        vq.push_back('{1051, 1'b1, 8'd254, 8'd255, 8'd255, 1'b1, 8'd246, 8'd247, 1'b0});
        vq.push_back('{1052, 1'b0, 8'd0,   8'd0,   8'd0,   1'b1, 8'd248, 8'd249, 1'b0});
        vq.push_back('{1055, 1'b0, 8'd0,   8'd0,   8'd0,   1'b1, 8'd254, 8'd255, 1'b0});
        vq.push_back('{1056, 1'b0, 8'd0,   8'd0,   8'd0,   1'b0, 8'd0,   8'd0,   1'b1});
        vq.push_back('{1057, 1'b0, 8'd0,   8'd0,   8'd0,   1'b0, 8'd0,   8'd0,   1'b0});

        rom[0] = '0;
        for (int i = 1; i < N; i++) rom[i] = W'($urandom_range(1, Q - 1));

        // ---- reset values ----
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst rd_en", rd_en, 0);
        check("rst wr_en", wr_en, 0);
        check("rst rd_addr0", rd_addr0, 0);
        check("rst rd_addr1", rd_addr1, 0);
        check("rst tw_addr", tw_addr, 0);
        check("rst wr_addr0", wr_addr0, 0);
        check("rst wr_addr1", wr_addr1, 0);
`ifdef NTT_STAGE_CTRL_CYCCNT_EN
        check("rst cycle_count", cycle_count, 0);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle busy", busy, 0);

        // ---- impulse run with full output trace; stray starts while busy and in DONE ----
        for (int i = 0; i < N; i++) mem[i] = '0;
        mem[0] = W'(1);
        pulse_start();
        for (int c = 0; c < LOG_LEN; c++) begin
            @(negedge clk);
            l_rd_en[c] = rd_en;
            l_wr_en[c] = wr_en;
            l_done[c]  = done;
            l_busy[c]  = busy;
            l_a0[c]    = rd_addr0;
            l_a1[c]    = rd_addr1;
            l_tw[c]    = tw_addr;
            l_w0[c]    = wr_addr0;
            l_w1[c]    = wr_addr1;
            start      = (c == 10 || c == 1056);
        end
        start = 1'b0;

        foreach (vq[v]) begin
            check($sformatf("c%0d rd_en", vq[v].cyc), l_rd_en[vq[v].cyc], vq[v].rd_en);
            if (vq[v].rd_en) begin
                check($sformatf("c%0d rd_addr0", vq[v].cyc), l_a0[vq[v].cyc], vq[v].a0);
                check($sformatf("c%0d rd_addr1", vq[v].cyc), l_a1[vq[v].cyc], vq[v].a1);
                check($sformatf("c%0d tw_addr", vq[v].cyc), l_tw[vq[v].cyc], vq[v].tw);
            end
            check($sformatf("c%0d wr_en", vq[v].cyc), l_wr_en[vq[v].cyc], vq[v].wr_en);
            if (vq[v].wr_en) begin
                check($sformatf("c%0d wr_addr0", vq[v].cyc), l_w0[vq[v].cyc], vq[v].w0);
                check($sformatf("c%0d wr_addr1", vq[v].cyc), l_w1[vq[v].cyc], vq[v].w1);
            end
            check($sformatf("c%0d done", vq[v].cyc), l_done[vq[v].cyc], vq[v].done);
        end

        check("c0 busy", l_busy[0], 1);
        check("c1055 busy", l_busy[1055], 1);
        check("c1057 busy", l_busy[1057], 0);
        check("c1058 busy", l_busy[1058], 0);
        check("c1058 rd_en", l_rd_en[1058], 0);

        n_rd = 0; n_wr = 0; n_tw0 = 0; n_drain_rd = 0;
        for (int c = 0; c < LOG_LEN; c++) begin
            if (l_rd_en[c]) n_rd++;
            if (l_wr_en[c]) n_wr++;
            if (l_rd_en[c] && l_tw[c] == '0) n_tw0++;
            if (c < 1056 && (c % 132) >= 128 && l_rd_en[c]) n_drain_rd++;
        end
        check("total reads", n_rd, 1024);
        check("total writes", n_wr, 1024);
        check("tw_addr zero while reading", n_tw0, 0);
        check("reads during drain", n_drain_rd, 0);

        for (int i = 0; i < N; i++) ref_a[i] = 1;
        compare_mem("impulse");

        // ---- random vectors against software NTT ----
        load_random();
        run_full("rand0");
        load_random();
        run_full("rand1");

        // ---- reset during stage 3, then a fresh run ----
        load_random();
        pulse_start();
        repeat (401) @(negedge clk);
        check("c400 busy", busy, 1);
        check("c400 wr_en", wr_en, 1);
        check("c400 wr_addr1", wr_addr1, 16);
        reset = 1'b1;
        @(negedge clk);
        check("post-reset wr_en", wr_en, 0);
        check("post-reset busy", busy, 0);
        check("post-reset rd_en", rd_en, 0);
        check("post-reset done", done, 0);
        reset = 1'b0;
        @(negedge clk);
        load_random();
        run_full("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
